// File: rtl/turnstile_rotation_decoder.sv
// Turnstile rotation decoder.
// Conditions the two optical sensors on the turnstile arm, tracks the Gray-coded
// rotation and reports completed entries/exits plus a saturating occupancy count.
//
// Ports
//   CLK       system clock, rising edge
//   RST       synchronous reset, active high
//   SENS_A    raw sensor A (1 = beam blocked), asynchronous
//   SENS_B    raw sensor B (1 = beam blocked), asynchronous
//   DIR       rotation in progress: [1] entering, [0] exiting
//   PASS_IN   one-cycle pulse on completed entry
//   PASS_OUT  one-cycle pulse on completed exit
//   OCC       occupancy, saturating 0..MAX_OCC
//   HEX0      active-low 7-segment, [6] = a .. [0] = g
//   LEDG      idle/ready
//   LEDR      [1] error, [0] full
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | arm at rest, filtered sensors 00
// IN1   | entry started, sensors 10
// IN2   | entry half way, sensors 11
// IN3   | entry nearly done, sensors 01
// OUT1  | exit started, sensors 01
// OUT2  | exit half way, sensors 11
// OUT3  | exit nearly done, sensors 10
// ERR   | illegal jump or stalled rotation; waits for 00
module turnstile_rotation_decoder #(
    parameter int DEB_CYCLES = 50000,
    parameter int TIMEOUT    = 250000000,
    parameter int OCC_W      = 8,
    parameter int MAX_OCC    = 200
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SENS_A,
    input  logic             SENS_B,
    output logic [1:0]       DIR,
    output logic             PASS_IN,
    output logic             PASS_OUT,
    output logic [OCC_W-1:0] OCC,
    output logic [6:0]       HEX0,
    output logic             LEDG,
    output logic [1:0]       LEDR
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OCC);

    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_E     = 7'b0110000;
    localparam logic [6:0] HEX_S     = 7'b0100100;
    localparam logic [6:0] HEX_DASH  = 7'b1111110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN1,
        S_IN2,
        S_IN3,
        S_OUT1,
        S_OUT2,
        S_OUT3,
        S_ERR
    } state_t;

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       filt_q, filt_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    state_t           state_q, state_d;
    logic             pass_in_q, pass_in_d;
    logic             pass_out_q, pass_out_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [1:0]       dir_q, dir_d;
    logic [6:0]       hex_q, hex_d;
    logic             ledg_q, ledg_d;
    logic [1:0]       ledr_q, ledr_d;
    logic             rotating;

    // Debounce: deb_q holds the samples still needed before the synchronized
    // pair is accepted. sync1 != sync2 means sync2 is about to change, so the
    // count restarts for the value that arrives next.
    always_comb begin
        sync1_d = {SENS_A, SENS_B};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        deb_d   = deb_q;
        if (sync2_q != filt_q && deb_q <= DEB_W'(1)) begin
            filt_d = sync2_q;
            deb_d  = DEB_LOAD;
        end else if (sync1_q != sync2_q || sync2_q == filt_q) begin
            deb_d = DEB_LOAD;
        end else begin
            deb_d = deb_q - DEB_W'(1);
        end
    end

    assign rotating = state_q inside {S_IN1, S_IN2, S_IN3, S_OUT1, S_OUT2, S_OUT3};

    always_comb begin
        state_d    = state_q;
        tmo_d      = TMO_LOAD;
        pass_in_d  = 1'b0;
        pass_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                case (filt_q)
                    2'b10:   state_d = S_IN1;
                    2'b01:   state_d = S_OUT1;
                    2'b11:   state_d = S_ERR;
                    default: state_d = S_IDLE;
                endcase
            end
            S_IN1: begin
                case (filt_q)
                    2'b11:   state_d = S_IN2;
                    2'b00:   state_d = S_IDLE;
                    2'b01:   state_d = S_ERR;
                    default: state_d = S_IN1;
                endcase
            end
            S_IN2: begin
                case (filt_q)
                    2'b01:   state_d = S_IN3;
                    2'b10:   state_d = S_IN1;
                    2'b00:   state_d = S_ERR;
                    default: state_d = S_IN2;
                endcase
            end
            S_IN3: begin
                case (filt_q)
                    2'b00: begin
                        state_d   = S_IDLE;
                        pass_in_d = 1'b1;
                    end
                    2'b11:   state_d = S_IN2;
                    2'b10:   state_d = S_ERR;
                    default: state_d = S_IN3;
                endcase
            end
            S_OUT1: begin
                case (filt_q)
                    2'b11:   state_d = S_OUT2;
                    2'b00:   state_d = S_IDLE;
                    2'b10:   state_d = S_ERR;
                    default: state_d = S_OUT1;
                endcase
            end
            S_OUT2: begin
                case (filt_q)
                    2'b10:   state_d = S_OUT3;
                    2'b01:   state_d = S_OUT1;
                    2'b00:   state_d = S_ERR;
                    default: state_d = S_OUT2;
                endcase
            end
            S_OUT3: begin
                case (filt_q)
                    2'b00: begin
                        state_d    = S_IDLE;
                        pass_out_d = 1'b1;
                    end
                    2'b11:   state_d = S_OUT2;
                    2'b01:   state_d = S_ERR;
                    default: state_d = S_OUT3;
                endcase
            end
            S_ERR: begin
                if (filt_q == 2'b00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Stall timer only runs while the arm sits part-way through a rotation;
        // any state change reloads it.
        if (rotating && state_d == state_q) begin
            if (tmo_q == '0) state_d = S_ERR;
            else             tmo_d   = tmo_q - TMO_W'(1);
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (pass_in_d && occ_q < OCC_MAX)      occ_d = occ_q + OCC_W'(1);
        else if (pass_out_d && occ_q != '0)    occ_d = occ_q - OCC_W'(1);
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        dir_d  = 2'b00;
        hex_d  = HEX_BLANK;
        ledg_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                ledg_d = 1'b1;
            end
            S_IN1, S_IN2, S_IN3: begin
                dir_d = 2'b10;
                hex_d = HEX_E;
            end
            S_OUT1, S_OUT2, S_OUT3: begin
                dir_d = 2'b01;
                hex_d = HEX_S;
            end
            S_ERR: begin
                hex_d = HEX_DASH;
            end
            default: hex_d = HEX_BLANK;
        endcase
        ledr_d = {state_d == S_ERR, occ_d == OCC_MAX};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            filt_q     <= 2'b00;
            deb_q      <= '0;
            tmo_q      <= '0;
            state_q    <= S_IDLE;
            pass_in_q  <= 1'b0;
            pass_out_q <= 1'b0;
            occ_q      <= '0;
            dir_q      <= 2'b00;
            hex_q      <= HEX_BLANK;
            ledg_q     <= 1'b1;
            ledr_q     <= 2'b00;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            deb_q      <= deb_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            pass_in_q  <= pass_in_d;
            pass_out_q <= pass_out_d;
            occ_q      <= occ_d;
            dir_q      <= dir_d;
            hex_q      <= hex_d;
            ledg_q     <= ledg_d;
            ledr_q     <= ledr_d;
        end
    end

    assign DIR      = dir_q;
    assign PASS_IN  = pass_in_q;
    assign PASS_OUT = pass_out_q;
    assign OCC      = occ_q;
    assign HEX0     = hex_q;
    assign LEDG     = ledg_q;
    assign LEDR     = ledr_q;

endmodule

// File: doc/turnstile_rotation_decoder.md
Name: turnstile_rotation_decoder

Overview:
- Reads the two optical sensors on the turnstile arm and decodes the arm rotation into completed entries and exits.
- Produces single-cycle passage pulses, a live direction indication in the same SW[1]=entering / SW[0]=exiting encoding the gate controller uses, and a saturating occupancy count.
- Drives the direction display and status LEDs on the sensor end of the gate.

Parameters:
- DEB_CYCLES, 50000: consecutive stable synchronized cycles required before a sensor change is accepted; minimum 1.
- TIMEOUT, 250000000: maximum cycles allowed in a partial rotation with no accepted sensor change.
- OCC_W, 8: width of the occupancy counter.
- MAX_OCC, 200: occupancy saturation value; must be at most 2^OCC_W-1.

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous reset, active high
- SENS_A  in  1  raw sensor A (1 = beam blocked), asynchronous
- SENS_B  in  1  raw sensor B (1 = beam blocked), asynchronous
- DIR  out  2  rotation in progress: DIR[1] = entering, DIR[0] = exiting; never both 1
- PASS_IN  out  1  one-cycle pulse when an entry completes
- PASS_OUT  out  1  one-cycle pulse when an exit completes
- OCC  out  OCC_W  current occupancy
- HEX0  out  7  active-low 7-segment display; HEX0[6] = segment a, HEX0[0] = segment g
- LEDG  out  1  idle/ready
- LEDR  out  2  LEDR[1] = error, LEDR[0] = full (OCC == MAX_OCC)

Behaviour:
- Reset: RST sampled high on an edge forces the following, regardless of the current state, including mid-rotation:
  - FSM = IDLE; DIR = 00; PASS_IN = PASS_OUT = 0; OCC = 0
  - HEX0 = 1111111; LEDG = 1; LEDR = 00
  - synchronizers = 0; filtered value = 00; debounce and timeout counters = 0
- Input conditioning:
  - Each sensor passes through a 2-flop synchronizer.
  - The filtered pair F = {A,B} takes the synchronized pair once that pair has differed from F and stayed constant for DEB_CYCLES consecutive cycles.
  - Any change in the synchronized pair restarts the debounce count.
- FSM: all states and outputs are registered. Gray sequences on F:
  - Entry: 00 -> 10 -> 11 -> 01 -> 00
  - Exit: 00 -> 01 -> 11 -> 10 -> 00
- States: IDLE, IN1 (10), IN2 (11), IN3 (01), OUT1 (01), OUT2 (11), OUT3 (10), ERR.
- Transitions, evaluated on the edge after F changes:
  - From IDLE: F=10 -> IN1; F=01 -> OUT1; F=11 -> ERR.
  - Forward step -> next state in the same sequence.
  - Reversal to the previous code -> previous state. IN1 with F=00 -> IDLE, and OUT1 with F=00 -> IDLE, with no pulse.
  - IN3 with F=00 -> IDLE and PASS_IN = 1 for exactly one cycle.
  - OUT3 with F=00 -> IDLE and PASS_OUT = 1 for exactly one cycle.
  - A two-bit jump (00<->11 or 10<->01) from any state -> ERR.
  - Any non-IDLE, non-ERR state with no F change for TIMEOUT cycles -> ERR.
  - ERR -> IDLE on the edge after F is observed as 00. If F is already 00 on entry to ERR, ERR is held for one cycle.
- Latency:
  - A clean raw transition into 00 that completes an entry produces PASS_IN exactly 3+DEB_CYCLES edges after the raw change.
  - Breakdown: 2 synchronizer cycles, DEB_CYCLES debounce cycles, 1 FSM cycle.
- Occupancy:
  - OCC increments on PASS_IN and saturates at MAX_OCC; the pulse is still issued at saturation.
  - OCC decrements on PASS_OUT and saturates at 0; the pulse is still issued at 0.
  - PASS_IN and PASS_OUT are never simultaneous.
- Outputs by state:
  - DIR = 10 in IN1–IN3, 01 in OUT1–OUT3, 00 otherwise.
  - LEDG = 1 only in IDLE.
  - LEDR[1] = 1 only in ERR.
  - LEDR[0] = (OCC == MAX_OCC).
  - HEX0: IDLE 1111111; IN* 0110000 ("E"); OUT* 0100100 ("S"); ERR 1111110 ("-").

Test Plan (DEB_CYCLES=4, TIMEOUT=100, OCC_W=3, MAX_OCC=3):
- Clean entry: drive raw {A,B} 10, 11, 01, 00, each held 20 cycles. Required: DIR=10 and HEX0=0110000 during rotation; one PASS_IN pulse exactly 7 edges after the final 00 change; OCC 0->1; LEDG returns to 1.
- Bounce: toggle A for 3 cycles, then hold 10. Required: no transition until 4 stable cycles; a single IN1 entry; no spurious ERR.
- Partial entry reversed: drive 10, 11, 10, 00. Required: states IN1, IN2, IN1, IDLE; no PASS pulse; OCC unchanged.
- Saturation: 4 entries. Required: OCC saturates at 3 and LEDR[0]=1; the 4th PASS_IN still pulses. Then 4 exits: OCC goes to 0 and stays there, with 4 PASS_OUT pulses.
- Error handling:
  - Raw 00->11 directly: ERR, LEDR[1]=1, HEX0=1111110; then 00 returns to IDLE.
  - Hold 10 for 150 cycles: ERR after TIMEOUT.
- Reset mid-rotation: assert RST in state IN2 with OCC=2. Required: next edge gives all outputs at their reset values and OCC=0; with RST held, sensor activity is ignored.
